program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Writer side of the CPU instruction memory. It receives a framed program as a byte stream over a valid/ready handshake and writes each instruction byte into the 16x8 instruction memory. It holds the CPU in reset while loading and releases it only after the frame's checksum verifies. It sits between the host/debug byte source and the CPU's instruction-memory write port.

Parameters:
ADDR_W, 4, instruction memory address width
DATA_W, 8, instruction width ({opcode[7:4], data[3:0]})
DEPTH, 16, number of instruction words; maximum program length

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
load_start  input  1  single-cycle pulse requesting a new program load
in_valid  input  1  byte source has a byte on in_data
in_data  input  8  frame byte
in_ready  output  1  loader accepts in_data this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
cpu_reset  output  1  active-high reset to the CPU
busy  output  1  load in progress
done  output  1  last load succeeded; sticky until the next load_start
error  output  1  last load failed; sticky until the next load_start
word_count  output  5  number of instruction words written by the current or last load

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - cpu_reset=1; all other outputs 0.
  - Internal length, address and checksum registers are 0.
- Frame format:
  - One LEN byte: valid range is 1..16. in_data[7:5] must be 0 and in_data[4:0] must be 1..16.
  - Then LEN instruction bytes.
  - Then one CHK byte, equal to the 8-bit sum mod 256 of the instruction bytes.
- A transfer occurs on a rising edge when in_valid=1 and in_ready=1.
- in_ready is combinational: 1 only in states HDR, DATA and CHK. Bytes offered in other states are ignored and not consumed.
- States and transitions:
  - IDLE: load_start -> HDR. On the same edge: cpu_reset=1, busy=1, done=0, error=0, word_count=0, checksum=0, address=0.
  - HDR: on transfer, a valid LEN -> DATA with length latched. An invalid LEN -> ERR.
  - DATA: on each transfer:
    - The next cycle drives mem_we=1, mem_addr=address and mem_wdata=byte (1-cycle registered latency; mem_we is high for exactly one cycle per byte).
    - address and word_count increment by 1; checksum += byte (mod 256).
    - After the LEN-th byte -> CHK.
  - CHK: on transfer, if the byte equals the checksum -> DONE, else -> ERR.
  - DONE: busy=0, done=1, cpu_reset=0 (from the cycle after the CHK transfer). load_start -> HDR, with the same actions as from IDLE.
  - ERR: busy=0, error=1, cpu_reset stays 1. load_start -> HDR.
- load_start while busy (HDR/DATA/CHK) is ignored.
- Memory words at addresses >= LEN are not written and keep their old contents.
- Address wraps only through reset/restart; the maximum address is 15 (LEN=16). There is no wrap within a frame.
- in_valid deasserted mid-frame: the loader waits indefinitely in its current state, and no timeout applies.
- A reset during a load aborts immediately, returns to the reset values, and leaves cpu_reset=1. Partially written memory is not cleaned up.
- Back-to-back transfers are supported at 1 byte/cycle. Throughput is LEN+2 cycles per frame at full in_valid.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, DATA_W, DEPTH.
  - The opcode constants LOAD_A=4'b0001, LOAD_B=4'b0010, ADD=4'b0011, JUMP=4'b0100, OUT=4'b0101, used by the CPU and by bench program images.
  - The loader state enum (IDLE, HDR, DATA, CHK, DONE, ERR).
- One sub-module is natural: checksum_acc (8-bit clear/accumulate register with compare output). It is reused by a future readback/dump block.

Test Plan:
- Nominal load: after reset, pulse load_start, then stream 0x05, 0x1A, 0x21, 0x30, 0x50, 0x40, CHK 0xFB.
  - mem writes are addr0..4 = 0x1A, 0x21, 0x30, 0x50, 0x40, one mem_we pulse each, one cycle after acceptance.
  - Then done=1, cpu_reset=0, word_count=5.
- Bad checksum: the same frame with CHK 0xFA.
  - 5 writes occur, then error=1, done=0, cpu_reset=1, busy=0.
- Bad header: LEN bytes 0x00, 0x11 and 0x25 in separate loads.
  - Each goes to ERR with no mem_we, and in_ready drops after the LEN byte.
- Full length: LEN=0x10 with 16 bytes 0x01..0x10 and CHK 0x88.
  - Writes go to addr 0..15; word_count=16; done=1.
- Handshake stalls: random in_valid gaps on the nominal frame, plus bytes offered in IDLE/DONE and a load_start pulsed mid-DATA.
  - Results are identical to the nominal load; idle-state bytes are not consumed and the mid-load load_start has no effect.
- Reset mid-load: assert reset after 2 data bytes.
  - All outputs return to their reset values immediately (asynchronously) with cpu_reset=1.
  - A new nominal load then completes correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU constants, opcodes and program loader state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    localparam logic [3:0] LOAD_A = 4'b0001;
    localparam logic [3:0] LOAD_B = 4'b0010;
    localparam logic [3:0] ADD    = 4'b0011;
    localparam logic [3:0] JUMP   = 4'b0100;
    localparam logic [3:0] OUT    = 4'b0101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    // A LEN byte is legal only when the upper bits are clear and 1 <= LEN <= DEPTH.
    function automatic logic len_valid(input logic [7:0] b);
        return (b[7:5] == 3'd0) && (b[4:0] != 5'd0) && (b[4:0] <= 5'(DEPTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/checksum_acc.sv
`default_nettype none
// ============================================================================
// Module   : checksum_acc
// Brief    : 8-bit clear/accumulate register with equality compare output.
// Revision : 1.0 - initial release
// ============================================================================
module checksum_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_acc_en,
    input  logic [7:0] i_acc_data,
    input  logic [7:0] i_cmp_data,
    output logic       o_match
);

    logic [7:0] r_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= 8'd0;
        end else if (i_clear) begin
            r_sum <= 8'd0;
        end else if (i_acc_en) begin
            r_sum <= r_sum + i_acc_data;
        end
    end

    assign o_match = (r_sum == i_cmp_data);

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Framed byte-stream writer for the CPU instruction memory; holds
//            the CPU in reset until a frame's checksum verifies.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [4:0]        word_count
);

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic              w_ready;
    logic              w_start;
    logic              w_data_xfer;
    logic              w_sum_match;
    logic [4:0]        r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (load_start) begin
                    w_start      = 1'b1;
                    w_next_state = HDR;
                end
            end
            HDR: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = len_valid(in_data) ? DATA : ERR;
                end
            end
            DATA: begin
                w_ready = 1'b1;
                if (in_valid && ((r_word_count + 5'd1) == r_len)) begin
                    w_next_state = CHK;
                end
            end
            CHK: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = w_sum_match ? DONE : ERR;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_data_xfer = (r_state == DATA) && in_valid;

    // Memory write port is registered: each data byte appears one cycle after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len        <= 5'd0;
            r_addr       <= '0;
            r_word_count <= 5'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start) begin
                r_len        <= 5'd0;
                r_addr       <= '0;
                r_word_count <= 5'd0;
            end
            if ((r_state == HDR) && in_valid && len_valid(in_data)) begin
                r_len <= in_data[4:0];
            end
            if (w_data_xfer) begin
                r_mem_we     <= 1'b1;
                r_mem_addr   <= r_addr;
                r_mem_wdata  <= in_data;
                r_addr       <= r_addr + 1'b1;
                r_word_count <= r_word_count + 5'd1;
            end
        end
    end

    checksum_acc u_checksum_acc (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start),
        .i_acc_en   (w_data_xfer),
        .i_acc_data (in_data),
        .i_cmp_data (in_data),
        .o_match    (w_sum_match)
    );

    assign in_ready   = w_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_word_count;
    assign busy       = (r_state == HDR) || (r_state == DATA) || (r_state == CHK);
    assign done       = (r_state == DONE);
    assign error      = (r_state == ERR);
    assign cpu_reset  = (r_state != DONE);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Scoreboard bench for program_loader: directed frames, expected
//            memory writes queued by stimulus and popped by a write monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [4:0]        word_count;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (mem_we !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h:%0h expected=none", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("mem_write", {20'd0, mem_addr, mem_wdata}, {20'd0, e});
                end
            end
        end
    end

    task automatic status(input string name, input logic b, input logic d, input logic er,
                          input logic cr, input logic [4:0] wc);
        chk({name, "_busy"}, busy, b);
        chk({name, "_done"}, done, d);
        chk({name, "_error"}, error, er);
        chk({name, "_cpu_reset"}, cpu_reset, cr);
        chk({name, "_word_count"}, word_count, wc);
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%0h in_ready=0 required=1", b);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic offer_idle_bytes(input string name);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({name, "_in_ready"}, in_ready, 1'b0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Full frame: LEN, data bytes (expected writes queued), CHK.
    task automatic load_frame(input logic [7:0] f[$], input int gap_max, input bit mid_start);
        int gap;
        pulse_start();
        status("start", 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
        send(f[0]);
        for (int i = 1; i < f.size() - 1; i++) begin
            exp_q.push_back({4'(i - 1), f[i]});
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send(f[i]);
            if (mid_start && i == 2) pulse_start();
        end
        send(f[f.size() - 1]);
    endtask

    logic [7:0] nom[$]  = '{8'h05, 8'h1A, 8'h21, 8'h30, 8'h50, 8'h40, 8'hFB};
    logic [7:0] bad[$]  = '{8'h05, 8'h1A, 8'h21, 8'h30, 8'h50, 8'h40, 8'hFA};
    logic [7:0] hdrs[$] = '{8'h00, 8'h11, 8'h25};
    logic [7:0] full[$];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        repeat (3) @(negedge clk);
        status("reset", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_mem_we", mem_we, 1'b0);
        chk("reset_mem_addr", mem_addr, 4'd0);
        chk("reset_mem_wdata", mem_wdata, 8'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        offer_idle_bytes("idle");

        load_frame(nom, 0, 1'b0);
        status("nominal", 1'b0, 1'b1, 1'b0, 1'b0, 5'd5);

        load_frame(bad, 0, 1'b0);
        status("bad_chk", 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);

        foreach (hdrs[k]) begin
            pulse_start();
            send(hdrs[k]);
            chk("bad_hdr_in_ready", in_ready, 1'b0);
            status("bad_hdr", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
            repeat (2) @(posedge clk);
        end

        full.push_back(8'h10);
        for (int i = 1; i <= 16; i++) full.push_back(8'(i));
        full.push_back(8'h88);
        load_frame(full, 0, 1'b0);
        status("full", 1'b0, 1'b1, 1'b0, 1'b0, 5'd16);

        offer_idle_bytes("done_state");
        load_frame(nom, 3, 1'b1);
        status("stall", 1'b0, 1'b1, 1'b0, 1'b0, 5'd5);

        pulse_start();
        send(8'h05);
        exp_q.push_back({4'd0, 8'h1A});
        send(8'h1A);
        exp_q.push_back({4'd1, 8'h21});
        send(8'h21);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        status("midreset", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        chk("midreset_mem_we", mem_we, 1'b0);
        chk("midreset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        offer_idle_bytes("idle_after_reset");
        load_frame(nom, 0, 1'b0);
        status("after_reset", 1'b0, 1'b1, 1'b0, 1'b0, 5'd5);

        repeat (3) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
